lc3_mem_ctrl: RTL and testbench

- Memory-access stage for the LC-3 datapath. Holds the MAR and MDR.
- Runs the multi-cycle read/write handshake with external memory and returns the LC-3 ready signal (R) to the control unit.
- Decodes the four memory-mapped device registers: KBSR, KBDR, DSR, DDR.
- Sits between the bus and register file on one side and the memory/keyboard/display on the other. It consumes bus values that the 16-bit registers produce.

---
 rtl/lc3_mem_ctrl_if.sv | 53 +++++
 rtl/lc3_mem_ctrl.sv | 151 +++++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_ctrl_if
// Description : Signal bundle for the LC-3 memory-access stage. Covers the
//               datapath side (bus, loads, R), the external memory handshake
//               and the keyboard/display device pins.
// Revision    : 1.0 - initial release
// ============================================================================
interface lc3_mem_ctrl_if;
    // Datapath side
    logic [15:0] bus_in;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic        ready;
    logic [15:0] mar_out;
    logic [15:0] mdr_out;
    // Memory side
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    // Devices
    logic        kbd_valid;
    logic [7:0]  kbd_data;
    logic        disp_write;
    logic [7:0]  disp_data;
    logic        disp_done;

    // The memory-access stage itself
    modport slave (
        input  bus_in, ld_mar, ld_mdr, mio_en, r_w,
        output ready, mar_out, mdr_out,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        input  kbd_valid, kbd_data, disp_done,
        output disp_write, disp_data
    );

    // Everything around it: control unit, memory, keyboard, display
    modport master (
        output bus_in, ld_mar, ld_mdr, mio_en, r_w,
        input  ready, mar_out, mdr_out,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        output kbd_valid, kbd_data, disp_done,
        input  disp_write, disp_data
    );
endinterface
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_ctrl
// Description : LC-3 memory-access stage. Holds MAR/MDR, runs the multi-cycle
//               memory handshake, produces the ready (R) signal and implements
//               the KBSR/KBDR/DSR/DDR memory-mapped device registers.
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_ctrl #(
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input  wire logic         clk,
    input  wire logic         rst,
    lc3_mem_ctrl_if.slave     ctrl_if
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [15:0] mar_q;
    logic [15:0] mdr_q;
    logic        ready_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [15:0] mem_addr_q;
    logic [15:0] mem_wdata_q;
    logic        disp_write_q;
    logic [7:0]  disp_data_q;
    logic        kbsr_q;      // KBSR[15]: key available
    logic [7:0]  kbdr_q;
    logic        dsr_q;       // DSR[15]: display ready

    logic        w_is_dev;

    // Full 16-bit compare: only the four exact device addresses stay local
    assign w_is_dev = (mar_q == KBSR_ADDR) || (mar_q == KBDR_ADDR) ||
                      (mar_q == DSR_ADDR)  || (mar_q == DDR_ADDR);

    // Access FSM, register loads and device registers. Statement order matters:
    // disp_done is applied before the FSM so a same-cycle DDR write overrides
    // it, and kbd_valid after the FSM so a new key overrides a KBDR-read clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            mar_q        <= 16'h0000;
            mdr_q        <= 16'h0000;
            ready_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            disp_write_q <= 1'b0;
            disp_data_q  <= 8'h00;
            kbsr_q       <= 1'b0;
            kbdr_q       <= 8'h00;
            dsr_q        <= 1'b1;
        end else begin
            disp_write_q <= 1'b0;

            if (ctrl_if.disp_done) begin
                dsr_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (ctrl_if.ld_mar) begin
                        mar_q <= ctrl_if.bus_in;
                    end
                    if (ctrl_if.mio_en) begin
                        if (w_is_dev) begin
                            state_q <= ST_DONE;
                            ready_q <= 1'b1;
                            if (!ctrl_if.r_w) begin
                                if (mar_q == KBSR_ADDR) begin
                                    mdr_q <= {kbsr_q, 15'b0};
                                end else if (mar_q == KBDR_ADDR) begin
                                    mdr_q  <= {8'h00, kbdr_q};
                                    kbsr_q <= 1'b0;
                                end else if (mar_q == DSR_ADDR) begin
                                    mdr_q <= {dsr_q, 15'b0};
                                end else begin
                                    mdr_q <= 16'h0000;
                                end
                            end else if (mar_q == DDR_ADDR) begin
                                disp_data_q  <= mdr_q[7:0];
                                disp_write_q <= 1'b1;
                                dsr_q        <= 1'b0;
                            end
                        end else begin
                            state_q     <= ST_MEM;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= mar_q;
                            mem_we_q    <= ctrl_if.r_w;
                            mem_wdata_q <= mdr_q;
                        end
                    end else if (ctrl_if.ld_mdr) begin
                        mdr_q <= ctrl_if.bus_in;
                    end
                end

                ST_MEM: begin
                    if (ctrl_if.mem_ack) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_DONE;
                        ready_q   <= 1'b1;
                        if (!mem_we_q) begin
                            mdr_q <= ctrl_if.mem_rdata;
                        end
                    end
                end

                ST_DONE: begin
                    if (!ctrl_if.mio_en) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    ready_q   <= 1'b0;
                    mem_req_q <= 1'b0;
                end
            endcase

            if (ctrl_if.kbd_valid) begin
                kbdr_q <= ctrl_if.kbd_data;
                kbsr_q <= 1'b1;
            end
        end
    end

    assign ctrl_if.ready      = ready_q;
    assign ctrl_if.mar_out    = mar_q;
    assign ctrl_if.mdr_out    = mdr_q;
    assign ctrl_if.mem_req    = mem_req_q;
    assign ctrl_if.mem_we     = mem_we_q;
    assign ctrl_if.mem_addr   = mem_addr_q;
    assign ctrl_if.mem_wdata  = mem_wdata_q;
    assign ctrl_if.disp_write = disp_write_q;
    assign ctrl_if.disp_data  = disp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_mem_ctrl
// Description : Directed bench for lc3_mem_ctrl: reset, memory read/write
//               handshakes, device register decode and same-cycle events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    lc3_mem_ctrl_if ifc ();

    lc3_mem_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_mar(input logic [15:0] v);
        ifc.bus_in = v;
        ifc.ld_mar = 1'b1;
        tick();
        ifc.ld_mar = 1'b0;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        ifc.bus_in = v;
        ifc.ld_mdr = 1'b1;
        tick();
        ifc.ld_mdr = 1'b0;
    endtask

    // Device read: one cycle to DONE, then release mio_en and return to IDLE
    task automatic dev_read(input logic [15:0] addr, input logic [15:0] exp, input string tag);
        load_mar(addr);
        ifc.mio_en = 1'b1;
        ifc.r_w    = 1'b0;
        tick();
        chk({tag, "_ready"}, {15'b0, ifc.ready}, 16'h0001);
        chk({tag, "_mdr"}, ifc.mdr_out, exp);
        ifc.mio_en = 1'b0;
        tick();
        chk({tag, "_idle"}, {15'b0, ifc.ready}, 16'h0000);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        rst            = 1'b1;
        ifc.bus_in     = 16'h0000;
        ifc.ld_mar     = 1'b0;
        ifc.ld_mdr     = 1'b0;
        ifc.mio_en     = 1'b0;
        ifc.r_w        = 1'b0;
        ifc.mem_rdata  = 16'h0000;
        ifc.mem_ack    = 1'b0;
        ifc.kbd_valid  = 1'b0;
        ifc.kbd_data   = 8'h00;
        ifc.disp_done  = 1'b0;
        tick();
        tick();
        chk("rst_ready", {15'b0, ifc.ready}, 16'h0000);
        chk("rst_mem_req", {15'b0, ifc.mem_req}, 16'h0000);
        chk("rst_disp_write", {15'b0, ifc.disp_write}, 16'h0000);
        rst = 1'b0;
        tick();

        // Start a memory access, then reset it mid-MEM
        load_mar(16'h5000);
        load_mdr(16'h7777);
        ifc.mio_en = 1'b1;
        ifc.r_w    = 1'b0;
        tick();
        chk("pre_rst_mem_req", {15'b0, ifc.mem_req}, 16'h0001);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_mem_req", {15'b0, ifc.mem_req}, 16'h0000);
        chk("async_rst_mar", ifc.mar_out, 16'h0000);
        chk("async_rst_mdr", ifc.mdr_out, 16'h0000);
        ifc.mio_en = 1'b0;
        tick();
        chk("rst_hold_ready", {15'b0, ifc.ready}, 16'h0000);
        rst = 1'b0;
        tick();
        chk("post_rst_mem_req", {15'b0, ifc.mem_req}, 16'h0000);
        dev_read(16'hFE04, 16'h8000, "rst_dsr");

        // Memory write, ack on third MEM cycle; ld_mar during MEM ignored
        load_mar(16'h3000);
        load_mdr(16'h1234);
        ifc.mio_en = 1'b1;
        ifc.r_w    = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("wr_req", {15'b0, ifc.mem_req}, 16'h0001);
            chk("wr_addr", ifc.mem_addr, 16'h3000);
            chk("wr_we", {15'b0, ifc.mem_we}, 16'h0001);
            chk("wr_wdata", ifc.mem_wdata, 16'h1234);
            chk("wr_ready_low", {15'b0, ifc.ready}, 16'h0000);
            if (i == 0) begin
                ifc.bus_in = 16'hFFFF;
                ifc.ld_mar = 1'b1;
            end else begin
                ifc.ld_mar = 1'b0;
            end
            if (i == 2) ifc.mem_ack = 1'b1;
            tick();
        end
        ifc.mem_ack = 1'b0;
        chk("wr_ready", {15'b0, ifc.ready}, 16'h0001);
        chk("wr_req_dropped", {15'b0, ifc.mem_req}, 16'h0000);
        chk("mem_ld_mar_ignored", ifc.mar_out, 16'h3000);
        chk("wr_mdr_kept", ifc.mdr_out, 16'h1234);
        ifc.mio_en = 1'b0;
        tick();
        chk("wr_idle", {15'b0, ifc.ready}, 16'h0000);

        // Memory read with immediate ack; then hold mio_en in DONE
        load_mar(16'h4000);
        ifc.mio_en = 1'b1;
        ifc.r_w    = 1'b0;
        tick();
        chk("rd_req", {15'b0, ifc.mem_req}, 16'h0001);
        chk("rd_we", {15'b0, ifc.mem_we}, 16'h0000);
        chk("rd_addr", ifc.mem_addr, 16'h4000);
        chk("rd_ready_low", {15'b0, ifc.ready}, 16'h0000);
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = 16'hBEEF;
        tick();
        ifc.mem_ack   = 1'b0;
        ifc.mem_rdata = 16'h0000;
        chk("rd_ready", {15'b0, ifc.ready}, 16'h0001);
        chk("rd_mdr", ifc.mdr_out, 16'hBEEF);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("done_no_req", {15'b0, ifc.mem_req}, 16'h0000);
            chk("done_ready", {15'b0, ifc.ready}, 16'h0001);
        end
        ifc.mio_en = 1'b0;
        tick();
        chk("rd_idle", {15'b0, ifc.ready}, 16'h0000);

        // Keyboard
        ifc.kbd_valid = 1'b1;
        ifc.kbd_data  = 8'h41;
        tick();
        ifc.kbd_valid = 1'b0;
        dev_read(16'hFE00, 16'h8000, "kbsr_set");
        dev_read(16'hFE02, 16'h0041, "kbdr");
        dev_read(16'hFE00, 16'h0000, "kbsr_clr");

        // New key in the same cycle as a KBDR read
        load_mar(16'hFE02);
        ifc.mio_en    = 1'b1;
        ifc.r_w       = 1'b0;
        ifc.kbd_valid = 1'b1;
        ifc.kbd_data  = 8'h42;
        tick();
        ifc.kbd_valid = 1'b0;
        chk("kbdr_race_old", ifc.mdr_out, 16'h0041);
        ifc.mio_en = 1'b0;
        tick();
        dev_read(16'hFE00, 16'h8000, "kbsr_race");
        dev_read(16'hFE02, 16'h0042, "kbdr_race_new");

        // Display write
        load_mdr(16'h0A5A);
        load_mar(16'hFE06);
        ifc.mio_en = 1'b1;
        ifc.r_w    = 1'b1;
        tick();
        chk("ddr_pulse", {15'b0, ifc.disp_write}, 16'h0001);
        chk("ddr_data", {8'h00, ifc.disp_data}, 16'h005A);
        chk("ddr_ready", {15'b0, ifc.ready}, 16'h0001);
        chk("ddr_no_mem", {15'b0, ifc.mem_req}, 16'h0000);
        ifc.mio_en = 1'b0;
        tick();
        chk("ddr_pulse_end", {15'b0, ifc.disp_write}, 16'h0000);
        dev_read(16'hFE04, 16'h0000, "dsr_busy");
        ifc.disp_done = 1'b1;
        tick();
        ifc.disp_done = 1'b0;
        dev_read(16'hFE04, 16'h8000, "dsr_done");

        // DDR write and disp_done together: write wins
        load_mdr(16'h0033);
        load_mar(16'hFE06);
        ifc.mio_en    = 1'b1;
        ifc.r_w       = 1'b1;
        ifc.disp_done = 1'b1;
        tick();
        ifc.disp_done = 1'b0;
        chk("ddr2_data", {8'h00, ifc.disp_data}, 16'h0033);
        ifc.mio_en = 1'b0;
        tick();
        dev_read(16'hFE04, 16'h0000, "dsr_race");

        // Near-device address goes to memory
        load_mar(16'hFE01);
        ifc.mio_en = 1'b1;
        ifc.r_w    = 1'b0;
        tick();
        chk("fe01_req", {15'b0, ifc.mem_req}, 16'h0001);
        chk("fe01_addr", ifc.mem_addr, 16'hFE01);
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = 16'h1111;
        tick();
        ifc.mem_ack = 1'b0;
        chk("fe01_mdr", ifc.mdr_out, 16'h1111);
        ifc.mio_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
